// File: rtl/if_id_pipe_reg_if.sv
// IF/ID stage bundle: fetch-side push, decode-side pop,
// flush and occupancy. The stage itself uses the slave modport.
interface if_id_pipe_reg_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    new_pc;
    logic [INSTR_W-1:0] instruction;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         occupancy;

    modport master (
        output flush, in_valid, new_pc, instruction, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, occupancy
    );

    modport slave (
        input  flush, in_valid, new_pc, instruction, out_ready,
        output in_ready, out_valid, out_pc, out_instr, occupancy
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: ready/valid stage with a 1-entry
// skid buffer, flush-to-bubble, depth-2 strict FIFO order.
module if_id_pipe_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
    input logic clk,
    input logic rst,
    if_id_pipe_reg_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               rdy;
    logic               vld;
    logic [1:0]         occ;
    logic               accept;
    logic               consume;

    assign accept  = bus.in_valid & rdy;
    assign consume = vld & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) state_nxt = FULL;
                FULL: begin
                    if (accept && !consume) begin
                        state_nxt = SKID;
                    end else if (!accept && consume) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: if (consume) state_nxt = FULL;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        rdy = 1'b1;
        vld = 1'b0;
        occ = 2'd0;
        unique case (state)
            EMPTY: begin
                rdy = 1'b1;
                vld = 1'b0;
                occ = 2'd0;
            end
            FULL: begin
                rdy = 1'b1;
                vld = 1'b1;
                occ = 2'd1;
            end
            SKID: begin
                rdy = 1'b0;
                vld = 1'b1;
                occ = 2'd2;
            end
            default: begin
                rdy = 1'b1;
                vld = 1'b0;
                occ = 2'd0;
            end
        endcase
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.occupancy = occ;
    assign bus.out_pc    = head_pc;
    assign bus.out_instr = vld ? head_instr : NOP_INSTR;

    // Head is left untouched on drain or flush so out_pc holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc    <= '0;
            head_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else if (!bus.flush) begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        head_pc    <= bus.new_pc;
                        head_instr <= bus.instruction;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        head_pc    <= bus.new_pc;
                        head_instr <= bus.instruction;
                    end else if (accept) begin
                        skid_pc    <= bus.new_pc;
                        skid_instr <= bus.instruction;
                    end
                end
                SKID: begin
                    if (consume) begin
                        head_pc    <= skid_pc;
                        head_instr <= skid_instr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios plus
// randomized traffic against a 2-deep queue model.
module tb_if_id_pipe_reg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ent_t        mq[$];
    logic [31:0] m_pc = '0;

    always #5 clk = ~clk;

    if_id_pipe_reg_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    if_id_pipe_reg #(
        .PC_W(PC_W),
        .INSTR_W(INSTR_W),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", n, $time, act, exp);
        end
    endtask

    // Reference: a FIFO of capacity 2 seen from the outside.
    always @(posedge clk) begin
        bit acc;
        bit con;
        acc = bus.in_valid && (mq.size() < 2);
        con = bus.out_ready && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            m_pc = '0;
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back('{bus.new_pc, bus.instruction});
        end
        if (mq.size() > 0) m_pc = mq[0].pc;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", {31'd0, bus.in_ready},
                {31'd0, mq.size() < 2});
            chk("cyc_out_valid", {31'd0, bus.out_valid},
                {31'd0, mq.size() > 0});
            chk("cyc_occupancy", {30'd0, bus.occupancy}, mq.size());
            chk("cyc_out_pc", bus.out_pc, m_pc);
            chk("cyc_out_instr", bus.out_instr,
                (mq.size() > 0) ? mq[0].ins : NOP);
        end
    end

    task automatic step(input bit iv, input logic [31:0] pc,
                        input logic [31:0] ins, input bit ordy,
                        input bit fl);
        bus.in_valid    = iv;
        bus.new_pc      = pc;
        bus.instruction = ins;
        bus.out_ready   = ordy;
        bus.flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input bit v, input logic [31:0] pc,
                       input logic [31:0] ins, input bit rdy,
                       input logic [1:0] occ);
        chk({n, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({n, "_pc"}, bus.out_pc, pc);
        chk({n, "_instr"}, bus.out_instr, ins);
        chk({n, "_in_ready"}, {31'd0, bus.in_ready}, {31'd0, rdy});
        chk({n, "_occ"}, {30'd0, bus.occupancy}, {30'd0, occ});
    endtask

    initial begin
        logic [31:0] seq;
        bus.in_valid    = 1'b0;
        bus.new_pc      = '0;
        bus.instruction = '0;
        bus.out_ready   = 1'b0;
        bus.flush       = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        lit("reset", 0, 32'h0, NOP, 1, 2'd0);

        step(1, 32'h0, 32'h8C01_0000, 1, 0);
        lit("stream0", 1, 32'h0, 32'h8C01_0000, 1, 2'd1);
        step(1, 32'h4, 32'h8C02_0004, 1, 0);
        lit("stream1", 1, 32'h4, 32'h8C02_0004, 1, 2'd1);
        step(1, 32'h8, 32'h0022_1820, 1, 0);
        lit("stream2", 1, 32'h8, 32'h0022_1820, 1, 2'd1);
        step(0, 32'h0, 32'h0, 1, 0);
        lit("drain", 0, 32'h8, NOP, 1, 2'd0);

        step(1, 32'h10, 32'hA000_0010, 0, 0);
        lit("stall1", 1, 32'h10, 32'hA000_0010, 1, 2'd1);
        step(1, 32'h14, 32'hA000_0014, 0, 0);
        lit("stall2", 1, 32'h10, 32'hA000_0010, 0, 2'd2);
        step(1, 32'h18, 32'hA000_0018, 0, 0);
        lit("stall_hold", 1, 32'h10, 32'hA000_0010, 0, 2'd2);
        step(1, 32'h18, 32'hA000_0018, 1, 0);
        lit("release14", 1, 32'h14, 32'hA000_0014, 1, 2'd1);
        step(1, 32'h18, 32'hA000_0018, 1, 0);
        lit("release18", 1, 32'h18, 32'hA000_0018, 1, 2'd1);
        step(0, 32'h0, 32'h0, 1, 0);
        lit("release_end", 0, 32'h18, NOP, 1, 2'd0);

        step(1, 32'h30, 32'hB000_0030, 0, 0);
        step(1, 32'h34, 32'hB000_0034, 0, 0);
        lit("pre_flush", 1, 32'h30, 32'hB000_0030, 0, 2'd2);
        step(1, 32'h20, 32'hC000_0020, 0, 1);
        lit("flush", 0, 32'h30, NOP, 1, 2'd0);
        step(0, 32'h0, 32'h0, 1, 0);
        lit("post_flush", 0, 32'h30, NOP, 1, 2'd0);

        step(1, 32'h40, 32'hD000_0040, 0, 0);
        step(1, 32'h44, 32'hD000_0044, 0, 0);
        lit("pre_rst", 1, 32'h40, 32'hD000_0040, 0, 2'd2);
        rst = 1'b1;
        step(1, 32'h48, 32'hD000_0048, 1, 0);
        rst = 1'b0;
        lit("mid_rst", 0, 32'h0, NOP, 1, 2'd0);
        step(0, 32'h0, 32'h0, 1, 0);
        lit("post_rst", 0, 32'h0, NOP, 1, 2'd0);

        seq = 32'h100;
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            step($urandom_range(0, 99) < 60, seq, $urandom,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3);
            seq = seq + 32'd4;
        end
        rst = 1'b0;
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
